// File: rtl/fp_pkg.sv
// Shared types and helpers for the IEEE-754 arithmetic blocks.
package fp_pkg;

   // Rounding-mode encoding as presented on the rm input
   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rm_e;

   // Bit positions inside the 5-bit exception flag vector
   localparam int unsigned FLG_NV = 4;
   localparam int unsigned FLG_DZ = 3;
   localparam int unsigned FLG_OF = 2;
   localparam int unsigned FLG_UF = 1;
   localparam int unsigned FLG_NX = 0;
   localparam int unsigned FLG_W  = 5;

   // Sequencer states of the iterative square-root unit
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PREP  = 2'd1,
      ST_ITER  = 2'd2,
      ST_ROUND = 2'd3
   } fsm_e;

   // Operand class; normal numbers have every bit clear
   typedef struct packed {
      logic zero;
      logic sub;
      logic inf;
      logic qnan;
      logic snan;
   } fp_class_t;

   // Width-agnostic classification from pre-reduced field predicates
   function automatic fp_class_t classify(input logic exp_zero, input logic exp_ones,
                                          input logic frac_zero, input logic quiet);
      fp_class_t c;
      c.zero = exp_zero & frac_zero;
      c.sub  = exp_zero & ~frac_zero;
      c.inf  = exp_ones & frac_zero;
      c.qnan = exp_ones & ~frac_zero & quiet;
      c.snan = exp_ones & ~frac_zero & ~quiet;
      return c;
   endfunction

   // Canonical quiet NaN {0, all-ones exponent, 1, 0...}, right-aligned in 64 bits
   function automatic logic [63:0] canonical_nan(input int unsigned exp_w, input int unsigned man_w);
      logic [63:0] v;
      v = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         if ((i + 1 >= man_w) && (i < man_w + exp_w)) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/fpsqrt_step.sv
// One radix-2 restoring square-root recurrence step (combinational).
module fpsqrt_step #(
   parameter int unsigned MAN_W = 23
) (
   input  logic [MAN_W+3:0] rem_i,
   input  logic [MAN_W+1:0] root_i,
   input  logic [1:0]       pair_i,
   output logic [MAN_W+3:0] rem_o,
   output logic             bit_o
);
   localparam int unsigned REM_W = MAN_W + 4;
   localparam int unsigned DIF_W = REM_W + 3;

   logic [DIF_W-1:0] lhs;
   logic [DIF_W-1:0] rhs;
   logic [DIF_W-1:0] trial;

   // Trial subtract {rem, pair} - {root, 01}; keep the shifted remainder when negative
   always_comb begin
      lhs   = DIF_W'({rem_i, pair_i});
      rhs   = DIF_W'({root_i, 2'b01});
      trial = lhs - rhs;
      bit_o = ~trial[DIF_W-1];
      rem_o = bit_o ? REM_W'(trial) : REM_W'(lhs);
   end

endmodule

// File: rtl/fpsqrt_iter.sv
// Iterative IEEE-754 square root: radix-2 recurrence, one root bit per cycle.
module fpsqrt_iter
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   op,
   input  logic [2:0]             rm,
   output logic                   busy,
   output logic                   done,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [4:0]             flags,
   output logic                   denorm
);
   localparam int unsigned W     = EXP_W + MAN_W + 1;
   localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
   localparam int unsigned ITER  = MAN_W + 2;
   localparam int unsigned REM_W = MAN_W + 4;
   localparam int unsigned RAD_W = 2 * ITER;
   localparam int unsigned CNT_W = $clog2(ITER);
   localparam int unsigned EW    = EXP_W + 2;

   fsm_e               state_q, state_d;
   logic [W-1:0]       op_q, op_d;
   logic [2:0]         rm_q, rm_d;
   logic [RAD_W-1:0]   rad_q, rad_d;
   logic [REM_W-1:0]   rem_q, rem_d;
   logic [ITER-1:0]    root_q, root_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic               spec_q, spec_d;
   logic [W-1:0]       spec_res_q, spec_res_d;
   logic               spec_nv_q, spec_nv_d;
   logic               spec_den_q, spec_den_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [W-1:0]       result_q, result_d;
   logic [FLG_W-1:0]   flags_q, flags_d;
   logic               denorm_q, denorm_d;

   logic               op_sgn;
   logic [EXP_W-1:0]   op_exp;
   logic [MAN_W-1:0]   op_frac;
   fp_class_t          cls;
   logic signed [EW-1:0] e_unb;
   logic signed [EW-1:0] e_half;
   logic [REM_W-1:0]   step_rem;
   logic               step_bit;
   logic               r_bit;
   logic               sticky;
   logic               inc;
   logic [MAN_W+1:0]   mant_sum;
   logic [MAN_W-1:0]   frac_out;
   logic [EXP_W-1:0]   exp_out;

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign flags  = flags_q;
   assign denorm = denorm_q;

   fpsqrt_step #(.MAN_W(MAN_W)) u_step (
      .rem_i  (rem_q),
      .root_i (root_q),
      .pair_i (rad_q[RAD_W-1 -: 2]),
      .rem_o  (step_rem),
      .bit_o  (step_bit)
   );

   // Operand decode and rounding datapath
   always_comb begin
      op_sgn   = op_q[W-1];
      op_exp   = op_q[W-2:MAN_W];
      op_frac  = op_q[MAN_W-1:0];
      cls      = classify(op_exp == '0, &op_exp, op_frac == '0, op_frac[MAN_W-1]);
      e_unb    = $signed({2'b00, op_exp}) - $signed(EW'(BIAS));
      e_half   = e_unb >>> 1;

      r_bit    = root_q[0];
      sticky   = |rem_q;
      case (rm_q)
         RM_RTZ, RM_RDN: inc = 1'b0;
         RM_RUP:         inc = r_bit | sticky;
         RM_RMM:         inc = r_bit;
         default:        inc = r_bit & (sticky | root_q[1]);
      endcase
      mant_sum = {1'b0, root_q[ITER-1:1]} + (MAN_W+2)'(inc);
      frac_out = mant_sum[MAN_W+1] ? mant_sum[MAN_W:1] : mant_sum[MAN_W-1:0];
      exp_out  = exp_q + EXP_W'(mant_sum[MAN_W+1]);
   end

   // Next-state and register-input logic
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rm_d       = rm_q;
      rad_d      = rad_q;
      rem_d      = rem_q;
      root_d     = root_q;
      cnt_d      = cnt_q;
      exp_d      = exp_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      spec_nv_d  = spec_nv_q;
      spec_den_d = spec_den_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;
      flags_d    = flags_q;
      denorm_d   = denorm_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = op;
               rm_d    = rm;
               busy_d  = 1'b1;
               state_d = ST_PREP;
            end
         end

         ST_PREP: begin
            // Odd exponent: fold one factor of 2 into the radicand so it lies in [1,4)
            rad_d  = e_unb[0] ? {1'b1, op_frac, {(MAN_W+3){1'b0}}}
                              : {2'b01, op_frac, {(MAN_W+2){1'b0}}};
            exp_d  = EXP_W'(e_half + $signed(EW'(BIAS)));
            rem_d  = '0;
            root_d = '0;
            cnt_d  = CNT_W'(ITER - 1);

            spec_d     = 1'b1;
            spec_nv_d  = 1'b0;
            spec_den_d = 1'b0;
            spec_res_d = '0;
            if (cls.snan | cls.qnan) begin
               spec_res_d = W'(canonical_nan(EXP_W, MAN_W));
               spec_nv_d  = cls.snan;
            end else if (cls.zero | cls.sub) begin
               spec_res_d = {op_sgn, {(W-1){1'b0}}};
               spec_den_d = cls.sub;
            end else if (op_sgn) begin
               spec_res_d = W'(canonical_nan(EXP_W, MAN_W));
               spec_nv_d  = 1'b1;
            end else if (cls.inf) begin
               spec_res_d = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
               spec_d = 1'b0;
            end
            state_d = ST_ITER;
         end

         ST_ITER: begin
            rad_d  = rad_q << 2;
            rem_d  = step_rem;
            root_d = {root_q[ITER-2:0], step_bit};
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == '0) state_d = ST_ROUND;
         end

         ST_ROUND: begin
            flags_d = '0;
            if (spec_q) begin
               result_d        = spec_res_q;
               flags_d[FLG_NV] = spec_nv_q;
               denorm_d        = spec_den_q;
            end else begin
               result_d        = {1'b0, exp_out, frac_out};
               flags_d[FLG_NX] = r_bit | sticky;
               denorm_d        = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         op_q       <= '0;
         rm_q       <= '0;
         rad_q      <= '0;
         rem_q      <= '0;
         root_q     <= '0;
         cnt_q      <= '0;
         exp_q      <= '0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         spec_nv_q  <= 1'b0;
         spec_den_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
         denorm_q   <= 1'b0;
      end else begin
         op_q       <= op_d;
         rm_q       <= rm_d;
         rad_q      <= rad_d;
         rem_q      <= rem_d;
         root_q     <= root_d;
         cnt_q      <= cnt_d;
         exp_q      <= exp_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         spec_nv_q  <= spec_nv_d;
         spec_den_q <= spec_den_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
         denorm_q   <= denorm_d;
      end
   end

endmodule

// File: tb/tb_fpsqrt_iter.sv
// Directed bench for fpsqrt_iter: f32 and f64 instances on a shared clock.
module tb_fpsqrt_iter;

   logic        clk;
   logic        reset;

   logic        start32;
   logic [31:0] op32;
   logic [2:0]  rm32;
   logic        busy32, done32, denorm32;
   logic [31:0] result32;
   logic [4:0]  flags32;

   logic        start64;
   logic [63:0] op64;
   logic [2:0]  rm64;
   logic        busy64, done64, denorm64;
   logic [63:0] result64;
   logic [4:0]  flags64;

   int n_checks = 0;
   int n_errors = 0;

   fpsqrt_iter #(.EXP_W(8), .MAN_W(23)) u_f32 (
      .clk(clk), .reset(reset), .start(start32), .op(op32), .rm(rm32),
      .busy(busy32), .done(done32), .result(result32), .flags(flags32), .denorm(denorm32)
   );

   fpsqrt_iter #(.EXP_W(11), .MAN_W(52)) u_f64 (
      .clk(clk), .reset(reset), .start(start64), .op(op64), .rm(rm64),
      .busy(busy64), .done(done64), .result(result64), .flags(flags64), .denorm(denorm64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Launch one f32 operation from a post-edge point and wait for done
   task automatic run32(input logic [31:0] a, input logic [2:0] m, output int lat, output int bcnt);
      start32 = 1'b1;
      op32    = a;
      rm32    = m;
      @(posedge clk); #1;
      start32 = 1'b0;
      lat  = 0;
      bcnt = busy32 ? 1 : 0;
      while (!done32 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (busy32) bcnt++;
      end
   endtask

   task automatic test32(input string tag, input logic [31:0] a, input logic [2:0] m,
                         input logic [31:0] exp_res, input logic [4:0] exp_flg, input logic exp_den);
      int lat, bcnt;
      run32(a, m, lat, bcnt);
      check_eq({tag, "/lat"},    64'(lat), 64'd27);
      check_eq({tag, "/busy"},   64'(bcnt), 64'd27);
      check_eq({tag, "/result"}, 64'(result32), 64'(exp_res));
      check_eq({tag, "/flags"},  64'(flags32), 64'(exp_flg));
      check_eq({tag, "/denorm"}, 64'(denorm32), 64'(exp_den));
   endtask

   initial begin
      int lat, bcnt, nd, first;
      logic [31:0] held_res;

      reset   = 1'b0;
      start32 = 1'b0; op32 = '0; rm32 = '0;
      start64 = 1'b0; op64 = '0; rm64 = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst/busy",   64'(busy32), 64'd0);
      check_eq("rst/done",   64'(done32), 64'd0);
      check_eq("rst/result", 64'(result32), 64'd0);
      check_eq("rst/flags",  64'(flags32), 64'd0);
      check_eq("rst/denorm", 64'(denorm32), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Exact roots across even, odd and negative exponents
      test32("sqrt4",     32'h40800000, 3'd0, 32'h40000000, 5'b00000, 1'b0);
      test32("sqrt9",     32'h41100000, 3'd0, 32'h40400000, 5'b00000, 1'b0);
      test32("sqrt0.25",  32'h3E800000, 3'd0, 32'h3F000000, 5'b00000, 1'b0);
      test32("sqrt0.5",   32'h3F000000, 3'd0, 32'h3F3504F3, 5'b00001, 1'b0);

      // Rounding modes on sqrt(2)
      test32("sqrt2/rne", 32'h40000000, 3'd0, 32'h3FB504F3, 5'b00001, 1'b0);
      test32("sqrt2/rtz", 32'h40000000, 3'd1, 32'h3FB504F3, 5'b00001, 1'b0);
      test32("sqrt2/rdn", 32'h40000000, 3'd2, 32'h3FB504F3, 5'b00001, 1'b0);
      test32("sqrt2/rup", 32'h40000000, 3'd3, 32'h3FB504F4, 5'b00001, 1'b0);
      test32("sqrt2/rmm", 32'h40000000, 3'd4, 32'h3FB504F3, 5'b00001, 1'b0);
      test32("sqrt2/rm7", 32'h40000000, 3'd7, 32'h3FB504F3, 5'b00001, 1'b0);

      // Special operands
      test32("neg1",      32'hBF800000, 3'd0, 32'h7FC00000, 5'b10000, 1'b0);
      test32("neginf",    32'hFF800000, 3'd0, 32'h7FC00000, 5'b10000, 1'b0);
      test32("snan",      32'h7F800001, 3'd0, 32'h7FC00000, 5'b10000, 1'b0);
      test32("qnan",      32'h7FC00000, 3'd0, 32'h7FC00000, 5'b00000, 1'b0);
      test32("negqnan",   32'hFFC00000, 3'd0, 32'h7FC00000, 5'b00000, 1'b0);
      test32("negzero",   32'h80000000, 3'd0, 32'h80000000, 5'b00000, 1'b0);
      test32("poszero",   32'h00000000, 3'd0, 32'h00000000, 5'b00000, 1'b0);
      test32("posinf",    32'h7F800000, 3'd0, 32'h7F800000, 5'b00000, 1'b0);
      test32("negsub",    32'h80000001, 3'd0, 32'h80000000, 5'b00000, 1'b1);
      test32("possub",    32'h00000001, 3'd0, 32'h00000000, 5'b00000, 1'b1);
      test32("one",       32'h3F800000, 3'd0, 32'h3F800000, 5'b00000, 1'b0);

      // start held for three edges: only one operation
      start32 = 1'b1; op32 = 32'h41100000; rm32 = 3'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start32 = 1'b0;
      nd = 0; first = -1; held_res = '0;
      for (int i = 3; i <= 70; i++) begin
         @(posedge clk); #1;
         if (done32) begin
            nd++;
            if (first < 0) begin
               first    = i;
               held_res = result32;
            end
         end
      end
      check_eq("hold/ndone",  64'(nd), 64'd1);
      check_eq("hold/lat",    64'(first), 64'd27);
      check_eq("hold/result", 64'(held_res), 64'h40400000);

      // Back-to-back: second start issued in the done cycle
      run32(32'h40800000, 3'd0, lat, bcnt);
      check_eq("b2b/first", 64'(result32), 64'h40000000);
      run32(32'h41100000, 3'd0, lat, bcnt);
      check_eq("b2b/lat",    64'(lat), 64'd27);
      check_eq("b2b/second", 64'(result32), 64'h40400000);

      // Reset at cycle 10 of an operation aborts it
      start32 = 1'b1; op32 = 32'h3F000000; rm32 = 3'd0;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check_eq("abort/busy",   64'(busy32), 64'd0);
      check_eq("abort/done",   64'(done32), 64'd0);
      check_eq("abort/result", 64'(result32), 64'd0);
      check_eq("abort/flags",  64'(flags32), 64'd0);
      check_eq("abort/denorm", 64'(denorm32), 64'd0);
      nd = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done32) nd++;
      end
      check_eq("abort/nodone", 64'(nd), 64'd0);

      // f64 sqrt(2)
      start64 = 1'b1; op64 = 64'h4000000000000000; rm64 = 3'd0;
      @(posedge clk); #1;
      start64 = 1'b0;
      lat = 0;
      while (!done64 && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("f64/lat",    64'(lat), 64'd56);
      check_eq("f64/result", result64, 64'h3FF6A09E667F3BCD);
      check_eq("f64/flags",  64'(flags64), 64'h01);
      check_eq("f64/denorm", 64'(denorm64), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fpsqrt_iter.md
Name: fpsqrt_iter

Overview:
- Parametrised, iterative IEEE-754 square-root unit: radix-2 digit recurrence, start/done handshake, one result bit per cycle.
- Successor to the fixed single-precision sqrt path inside the shared divider.
- Standalone. Format set by EXP_W/MAN_W (f32, f64, f16).
- Adds all five rounding modes, a busy indication and a fixed, format-derived latency.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width. Derived: W = EXP_W+MAN_W+1, BIAS = 2^(EXP_W-1)-1, ITER = MAN_W+2.

Ports:
- clk  in  1  clock.
- reset  in  1  reset: synchronous, active-low.
- start  in  1  request. Sampled on a rising edge only while busy=0.
- op  in  W  operand, IEEE format {sign, exp, frac}.
- rm  in  3  rounding mode. Sampled with start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  single-cycle pulse, result valid.
- result  out  W  rounded square root. Held until next acceptance.
- flags  out  5  {NV, DZ, OF, UF, NX}. Held with result.
- denorm  out  1  operand was subnormal and flushed. Held with result.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; busy=0, done=0, result=0, flags=0, denorm=0.
  - Reset mid-operation aborts the operation. No done is produced.
- States: IDLE -> PREP -> ITER -> ROUND -> IDLE.
  - IDLE: start=1 at edge k latches op and rm, then goes to PREP.
  - PREP (1 cycle):
    - Classify the operand.
    - Unbiased e = E-BIAS; mantissa = {1, frac}.
    - If e is odd: radicand shifted left 1 and e decremented, so the radicand lies in [1,4).
    - Result exponent = e/2 + BIAS (arithmetic shift).
    - Clear the partial root and remainder; iteration counter = ITER-1.
  - ITER (ITER cycles):
    - Each cycle: trial = {remainder, next two radicand bits} - {root, 01}.
    - If trial >= 0: root bit 1, remainder = trial. Otherwise root bit 0.
    - The counter decrements; leave ITER when it reaches 0.
    - Output: MAN_W+2 root bits (integer, fraction, round bit R). Sticky S = (remainder != 0).
  - ROUND (1 cycle): apply rm, assemble result and flags.
    - Next edge: done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start sampled at edge k gives done high in the cycle after edge k+ITER+2.
  - f32: done is high after edge k+27.
  - Latency is fixed for all operands, special cases included.
- busy=1 from edge k until the edge that raises done.
- start while busy=1 is ignored; the operation in flight is unaffected.
- start in the same cycle done is high is accepted, since busy=0 then.
- Rounding:
  - Root sign is always +, so RDN behaves as RTZ.
  - rm encoding: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
  - Encodings 101–111 are treated as RNE.
  - Increment rules:
    - RNE: R & (S | lsb).
    - RMM: R.
    - RUP: R | S.
    - RTZ, RDN: no increment.
  - A carry out of the mantissa increments the exponent and zeroes the fraction.
  - NX = R | S.
- Special cases (fixed latency, NX=0):
  - Any NaN gives canonical qNaN {0, all-1 exp, 1, 0...}. NV=1 only if the input is a signalling NaN (quiet bit 0).
  - Negative nonzero, including -inf, gives qNaN with NV=1.
  - ±0 gives ±0.
  - +inf gives +inf.
  - Subnormal is flushed to a zero of the same sign: result ±0, denorm=1.
- DZ, OF, UF are always 0 (sqrt of a normal cannot leave the normal range).

Decomposition:
- Package fp_pkg holds:
  - rm_e enum (RNE, RTZ, RDN, RUP, RMM).
  - Flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0.
  - fsm_e state enum.
  - Functions: classify (zero/sub/inf/qnan/snan) and canonical_nan(EXP_W, MAN_W).
- Sub-module fpsqrt_step: combinational single recurrence step.
  - Inputs: remainder, root, radicand bit pair.
  - Outputs: next remainder, root bit.
  - Parametrised by MAN_W.

Test Plan:
- f32, rm=RNE, op=0x40800000 (4.0) -> result 0x40000000, flags 00000, done exactly after edge start+27, busy high 27 cycles.
- op=0x40000000 (2.0): RNE -> 0x3FB504F3 flags 00001; RUP -> 0x3FB504F4 NX; RTZ and RDN -> 0x3FB504F3 NX.
- Specials:
  - 0xBF800000 -> 0x7FC00000 NV=1.
  - 0x7F800001 -> 0x7FC00000 NV=1.
  - 0x7FC00000 -> 0x7FC00000 flags 0.
  - 0x80000000 -> 0x80000000.
  - 0x7F800000 -> 0x7F800000.
- Subnormal 0x00000001 -> 0x00000000, denorm=1, flags 0.
  - Next operand 0x3F800000 -> 0x3F800000 with denorm cleared.
- Handshake: start held for 3 cycles -> one operation only.
  - Back-to-back start in the done cycle -> second result 27 cycles later.
  - reset=0 at cycle 10 of an operation -> no done, all outputs 0.
- f64 (EXP_W=11, MAN_W=52): op=0x4000000000000000 -> 0x3FF6A09E667F3BCD, NX=1, done after start+56.
